// File: rtl/mem_access_seq.sv
// mem_access_seq: splits byte/halfword/word load-store requests into single-byte ram beats.
// Build option: define MEM_MISALIGN_EN to sequence misaligned halfword/word accesses instead of faulting them.
module mem_access_seq #(
    parameter int ram_width = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_len,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rw,
    output logic [1:0]  mem_len,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exception,
    output logic [1:0]  dbg_state
);
    // Handshake: a request is taken on a rising edge where req_valid && req_ready; req_ready is
    // high only in IDLE. resp_valid is a one-cycle pulse with no backpressure.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Range checking belongs to the attached ram; the width is carried for integration only.
    localparam int unused_ram_width = ram_width;

    state_t      state, state_nxt;
    logic        we_q, sgn_q, fault_q;
    logic [1:0]  len_q, beat_q, last_q;
    logic [31:0] addr_q, wdata_q, acc_q;
    logic        accept, misaligned, pre_fault, last_beat;
    logic [23:0] unused_rdata;

    assign unused_rdata = mem_rdata[31:8];

    assign accept    = (state == IDLE) && req_valid;
    assign last_beat = (beat_q == last_q);

`ifdef MEM_MISALIGN_EN
    assign misaligned = 1'b0;
`else
    assign misaligned = ((req_len == 2'b01) && req_addr[0]) ||
                        ((req_len == 2'b10) && (req_addr[1:0] != 2'b00));
`endif

    assign pre_fault = (req_len == 2'b11) || misaligned;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = pre_fault ? RESP : ACCESS;
            ACCESS:  if (mem_exception || last_beat) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            fault_q <= 1'b0;
            len_q   <= 2'b00;
            beat_q  <= 2'b00;
            last_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            acc_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                sgn_q   <= req_signed;
                len_q   <= req_len;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                beat_q  <= 2'b00;
                acc_q   <= 32'h0;
                fault_q <= pre_fault;
                // last beat index: byte 0, halfword 1, word 3
                last_q  <= (req_len == 2'b00) ? 2'd0 : (req_len == 2'b01) ? 2'd1 : 2'd3;
            end else if (state == ACCESS) begin
                if (!we_q) acc_q[{beat_q, 3'b000} +: 8] <= mem_rdata[7:0];
                beat_q <= beat_q + 2'd1;
                if (mem_exception) fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_fault = (state == RESP) && fault_q;
        resp_rdata = 32'h0;
        mem_rw     = 1'b0;
        mem_len    = 2'b00;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        dbg_state  = state;
        if (state == ACCESS) begin
            mem_addr = addr_q + {30'b0, beat_q};
            mem_rw   = we_q;
            if (we_q) mem_wdata = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
        end
        if ((state == RESP) && !fault_q && !we_q) begin
            case (len_q)
                2'b00:   resp_rdata = {{24{sgn_q & acc_q[7]}}, acc_q[7:0]};
                2'b01:   resp_rdata = {{16{sgn_q & acc_q[15]}}, acc_q[15:0]};
                2'b10:   resp_rdata = acc_q;
                default: resp_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed vector table plus hand sequences for mem_access_seq with a byte ram model.
module tb_mem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_len;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_rw, mem_exception;
    logic [1:0]  mem_len, dbg_state;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    mem_access_seq #(.ram_width(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_len(req_len), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_rw(mem_rw), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_exception(mem_exception), .dbg_state(dbg_state)
    );

    // byte ram responder: valid range 0x0000..0x1FFF, combinational read
    logic [7:0] ram_q [0:8191] = '{default: 8'h00};

    always_comb begin
        mem_exception = (mem_addr >= 32'h2000);
        mem_rdata     = mem_exception ? 32'h0 : {24'h0, ram_q[mem_addr[12:0]]};
    end

    always @(posedge clk) begin
        if (mem_rw && !mem_exception) ram_q[mem_addr[12:0]] <= mem_wdata[7:0];
    end

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [1:0] len, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic fault, input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.len = len; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.fault = fault; v.rdata = rdata; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver: wait for ready, issue one request, follow its beats up to the response
    task automatic run_req(input vec_t v, input string tag);
        int   lat, waited, beats;
        logic got;
        logic [31:0] wd;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_we = v.we; req_len = v.len; req_signed = v.sgn;
        req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; beats = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                got = 1'b1;
            end else begin
                check($sformatf("%s beat%0d addr", tag, beats), mem_addr, v.addr + 32'(beats));
                check($sformatf("%s beat%0d rw", tag, beats), 32'(mem_rw), 32'(v.we));
                check($sformatf("%s beat%0d len", tag, beats), 32'(mem_len), 32'd0);
                if (v.we) begin
                    wd = (v.wdata >> (8 * beats)) & 32'hFF;
                    check($sformatf("%s beat%0d wdata", tag, beats), mem_wdata, wd);
                end
                beats++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " fault"}, 32'(resp_fault), 32'(v.fault));
        check({tag, " rdata"}, resp_rdata, v.rdata);
        check({tag, " resp rw"}, 32'(mem_rw), 32'd0);
        @(negedge clk);
        check({tag, " pulse end"}, 32'(resp_valid), 32'd0);
        check({tag, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_len = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 5));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 5));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFFFFDE, 2));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 32'h000000DE, 2));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFFDEAD, 3));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0000DEAD, 3));
        vecs.push_back(mk(1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 5));
`ifdef MEM_MISALIGN_EN
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0000ADBE, 3));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b0, 32'h00DEADBE, 5));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1FFE, 32'h44332211, 1'b1, 32'h0, 4));
`else
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h1FFE, 32'h44332211, 1'b1, 32'h0, 1));
`endif
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h200, 32'h12348081, 1'b0, 32'h0, 3));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 1'b0, 32'hFFFF8081, 3));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 1'b0, 32'hFFFFFF80, 2));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 1'b0, 32'h00000081, 2));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h300, 32'hAABBCC7F, 1'b0, 32'h0, 2));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0000007F, 2));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h2000, 32'h5566, 1'b1, 32'h0, 2));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h0, 2));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in reset ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_fault", 32'(resp_fault), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_rw", 32'(mem_rw), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_len", 32'(mem_len), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);

        foreach (vecs[i]) run_req(vecs[i], $sformatf("vec%0d", i));

        // ram contents left behind by stores, including a partially completed one
        check("ram 0x100", 32'(ram_q[13'h100]), 32'hEF);
        check("ram 0x103", 32'(ram_q[13'h103]), 32'hDE);
        check("ram 0x201", 32'(ram_q[13'h201]), 32'h80);
`ifdef MEM_MISALIGN_EN
        check("ram 0x1FFE", 32'(ram_q[13'h1FFE]), 32'h11);
        check("ram 0x1FFF", 32'(ram_q[13'h1FFF]), 32'h22);
`else
        check("ram 0x1FFE", 32'(ram_q[13'h1FFE]), 32'h00);
        check("ram 0x1FFF", 32'(ram_q[13'h1FFF]), 32'h00);
`endif

        // reset in the middle of a word load, then an immediate byte load
        @(negedge clk);
        req_we = 1'b0; req_len = 2'b10; req_signed = 1'b0;
        req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst T+1 resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst T+2 resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst T+3 ready", 32'(req_ready), 32'd1);
        check("rst T+3 resp_valid", 32'(resp_valid), 32'd0);
        check("rst T+3 mem_addr", mem_addr, 32'h0);
        check("rst T+3 mem_rw", 32'(mem_rw), 32'd0);
        req_len = 2'b00; req_addr = 32'h103; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("post rst beat addr", mem_addr, 32'h103);
        check("post rst beat resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("post rst resp_valid", 32'(resp_valid), 32'd1);
        check("post rst fault", 32'(resp_fault), 32'd0);
        check("post rst rdata", resp_rdata, 32'h000000DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
